// File: rtl/siphash_core_px.sv
// SipHash core with runtime c/d round counts, 1 or 2 SipRounds per clock,
// and SipHash-64 / SipHash-128 output modes.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   initialize_i            load v0..v3 from key_i (long_i sampled here)
//   compress_i              absorb mi_i using compression_rounds_i rounds
//   finalize_i              finalize using final_rounds_i rounds
//   long_i                  1 = 128-bit digest (when LONG_EN = 1)
//   compression_rounds_i    c, sampled on compress accept
//   final_rounds_i          d, sampled on finalize accept
//   key_i                   k0 = [63:0], k1 = [127:64]
//   mi_i                    little-endian message word
//   ready_o                 core idle, command may be issued
//   siphash_word_o          [63:0] = b0, [127:64] = b1 (0 in 64-bit mode)
//   siphash_word_valid_o    digest valid, cleared by initialize
//   cmd_error_o             1-cycle pulse for a command seen while busy

module siphash_core_px #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit LONG_EN          = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         initialize_i,
    input  logic         compress_i,
    input  logic         finalize_i,
    input  logic         long_i,
    input  logic [3:0]   compression_rounds_i,
    input  logic [3:0]   final_rounds_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  mi_i,
    output logic         ready_o,
    output logic [127:0] siphash_word_o,
    output logic         siphash_word_valid_o,
    output logic         cmd_error_o
);

    typedef struct packed {
        logic [63:0] v3;
        logic [63:0] v2;
        logic [63:0] v1;
        logic [63:0] v0;
    } sip_t;

    typedef enum logic [2:0] {
        IDLE,
        COMP_LOOP,
        COMP_END,
        FIN_LOOP,
        FIN_MID,
        FIN_END
    } fsm_e;

    function automatic logic [63:0] rotl(input logic [63:0] x,
                                         input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic sip_t sipround(input sip_t s);
        sip_t r;
        r    = s;
        r.v0 = r.v0 + r.v1;
        r.v1 = rotl(r.v1, 13) ^ r.v0;
        r.v0 = rotl(r.v0, 32);
        r.v2 = r.v2 + r.v3;
        r.v3 = rotl(r.v3, 16) ^ r.v2;
        r.v2 = r.v2 + r.v1;
        r.v1 = rotl(r.v1, 17) ^ r.v2;
        r.v2 = rotl(r.v2, 32);
        r.v0 = r.v0 + r.v3;
        r.v3 = rotl(r.v3, 21) ^ r.v0;
        return r;
    endfunction

    fsm_e         state_q, state_d;
    sip_t         v_q, v_d;
    logic [63:0]  mi_q, mi_d;
    logic [4:0]   ctr_q, ctr_d;
    logic [3:0]   rounds_q, rounds_d;
    logic         long_q, long_d;
    logic         pass2_q, pass2_d;
    logic [127:0] word_q, word_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;

    sip_t         rnd1, rnd2;
    logic [4:0]   remain;
    logic [4:0]   step;
    logic [4:0]   ctr_next;
    logic         two;
    logic         lng;
    logic [63:0]  fold;
    logic         loop_exit;
    sip_t         loop_v;

    assign rnd1   = sipround(v_q);
    assign rnd2   = sipround(rnd1);
    assign remain = {1'b0, rounds_q} - ctr_q;
    // Two rounds only when both are still owed, so odd counts end on a
    // single-round cycle.
    assign two      = (ROUNDS_PER_CYCLE == 2) && (remain >= 5'd2);
    assign step     = two ? 5'd2 : 5'd1;
    assign ctr_next = ctr_q + step;
    assign lng      = long_i & LONG_EN;
    assign fold     = v_q.v0 ^ v_q.v1 ^ v_q.v2 ^ v_q.v3;

    // Shared loop step for both compression and finalization. A zero
    // round count leaves the state untouched and exits after one cycle.
    always_comb begin
        loop_v    = v_q;
        loop_exit = 1'b1;
        if (ctr_q < {1'b0, rounds_q}) begin
            loop_v    = two ? rnd2 : rnd1;
            loop_exit = (ctr_next >= {1'b0, rounds_q});
        end
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        mi_d     = mi_q;
        ctr_d    = ctr_q;
        rounds_d = rounds_q;
        long_d   = long_q;
        pass2_d  = pass2_q;
        word_d   = word_q;
        valid_d  = valid_q;
        err_d    = (initialize_i | compress_i | finalize_i)
                   && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (initialize_i) begin
                    v_d.v0  = key_i[63:0]   ^ 64'h736f6d6570736575;
                    v_d.v1  = key_i[127:64] ^ 64'h646f72616e646f6d
                              ^ (lng ? 64'hee : 64'h0);
                    v_d.v2  = key_i[63:0]   ^ 64'h6c7967656e657261;
                    v_d.v3  = key_i[127:64] ^ 64'h7465646279746573;
                    long_d  = lng;
                    valid_d = 1'b0;
                end else if (compress_i) begin
                    v_d.v3   = v_q.v3 ^ mi_i;
                    mi_d     = mi_i;
                    ctr_d    = '0;
                    rounds_d = compression_rounds_i;
                    state_d  = COMP_LOOP;
                end else if (finalize_i) begin
                    v_d.v2   = v_q.v2
                               ^ {56'h0, (long_q ? 8'hee : 8'hff)};
                    ctr_d    = '0;
                    rounds_d = final_rounds_i;
                    pass2_d  = 1'b0;
                    state_d  = FIN_LOOP;
                end
            end
            COMP_LOOP: begin
                v_d = loop_v;
                if (ctr_q < {1'b0, rounds_q}) ctr_d = ctr_next;
                if (loop_exit) state_d = COMP_END;
            end
            COMP_END: begin
                v_d.v0  = v_q.v0 ^ mi_q;
                state_d = IDLE;
            end
            FIN_LOOP: begin
                v_d = loop_v;
                if (ctr_q < {1'b0, rounds_q}) ctr_d = ctr_next;
                if (loop_exit) begin
                    state_d = (long_q && !pass2_q) ? FIN_MID : FIN_END;
                end
            end
            FIN_MID: begin
                word_d[63:0] = fold;
                v_d.v1       = v_q.v1 ^ 64'hdd;
                ctr_d        = '0;
                pass2_d      = 1'b1;
                state_d      = FIN_LOOP;
            end
            FIN_END: begin
                if (long_q) word_d[127:64] = fold;
                else        word_d = {64'h0, fold};
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            v_q      <= '0;
            mi_q     <= '0;
            ctr_q    <= '0;
            rounds_q <= '0;
            long_q   <= 1'b0;
            pass2_q  <= 1'b0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            mi_q     <= mi_d;
            ctr_q    <= ctr_d;
            rounds_q <= rounds_d;
            long_q   <= long_d;
            pass2_q  <= pass2_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ready_o              = (state_q == IDLE);
    assign siphash_word_o       = word_q;
    assign siphash_word_valid_o = valid_q;
    assign cmd_error_o          = err_q;

endmodule

// File: tb/tb_siphash_core_px.sv
// Bench for siphash_core_px: one instance per ROUNDS_PER_CYCLE value,
// vector table plus hand-written busy/priority/reset sequences.
`timescale 1ns/1ps

module tb_siphash_core_px;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [127:0] key;
    logic         ini [2];
    logic         cmp [2];
    logic         fin [2];
    logic         lng [2];
    logic [3:0]   cr  [2];
    logic [3:0]   fr  [2];
    logic [63:0]  mi  [2];
    logic         rdy [2];
    logic [127:0] word[2];
    logic         vld [2];
    logic         err [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        siphash_core_px #(
            .ROUNDS_PER_CYCLE(g + 1),
            .LONG_EN(1'b1)
        ) u_dut (
            .clk                 (clk),
            .reset_n             (reset_n),
            .initialize_i        (ini[g]),
            .compress_i          (cmp[g]),
            .finalize_i          (fin[g]),
            .long_i              (lng[g]),
            .compression_rounds_i(cr[g]),
            .final_rounds_i      (fr[g]),
            .key_i               (key),
            .mi_i                (mi[g]),
            .ready_o             (rdy[g]),
            .siphash_word_o      (word[g]),
            .siphash_word_valid_o(vld[g]),
            .cmd_error_o         (err[g])
        );
    end

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];

    typedef struct {
        logic         lg;
        int           nw;
        logic [63:0]  m0, m1, m2;
        int           c, d;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input int u,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u=%0d: got %h want %h", nm, u, act, exp);
        end
    endtask

    // Reference SipHash model, straight from the algorithm description.
    logic [63:0] s0, s1, s2, s3;

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    task automatic sround();
        s0 = s0 + s1; s1 = rl(s1, 13) ^ s0; s0 = rl(s0, 32);
        s2 = s2 + s3; s3 = rl(s3, 16) ^ s2;
        s2 = s2 + s1; s1 = rl(s1, 17) ^ s2; s2 = rl(s2, 32);
        s0 = s0 + s3; s3 = rl(s3, 21) ^ s0;
    endtask

    task automatic ref_hash(input vec_t v, output logic [127:0] res);
        logic [63:0] w;
        logic [63:0] b0;
        s0 = key[63:0]   ^ 64'h736f6d6570736575;
        s1 = key[127:64] ^ 64'h646f72616e646f6d ^ (v.lg ? 64'hee : 64'h0);
        s2 = key[63:0]   ^ 64'h6c7967656e657261;
        s3 = key[127:64] ^ 64'h7465646279746573;
        for (int i = 0; i < v.nw; i++) begin
            w = (i == 0) ? v.m0 : (i == 1) ? v.m1 : v.m2;
            s3 ^= w;
            for (int r = 0; r < v.c; r++) sround();
            s0 ^= w;
        end
        s2 ^= (v.lg ? 64'hee : 64'hff);
        for (int r = 0; r < v.d; r++) sround();
        b0  = s0 ^ s1 ^ s2 ^ s3;
        res = {64'h0, b0};
        if (v.lg) begin
            s1 ^= 64'hdd;
            for (int r = 0; r < v.d; r++) sround();
            res[127:64] = s0 ^ s1 ^ s2 ^ s3;
        end
    endtask

    function automatic int kk(input int n, input int r);
        int k;
        k = (n + r - 1) / r;
        return (k < 1) ? 1 : k;
    endfunction

    // Issue one command on DUT u and return accept-to-ready cycle count.
    task automatic cmd(input int u, input int kind, output int lat);
        case (kind)
            0:       ini[u] = 1'b1;
            1:       cmp[u] = 1'b1;
            default: fin[u] = 1'b1;
        endcase
        @(negedge clk);
        ini[u] = 1'b0;
        cmp[u] = 1'b0;
        fin[u] = 1'b0;
        lat = 1;
        while (!rdy[u] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!rdy[u]) begin
            total++;
            bad++;
            $display("FAIL timeout u=%0d kind=%0d", u, kind);
        end
    endtask

    task automatic do_final(input int u, input logic lg, input int d,
                            input logic [127:0] exp);
        int lat;
        int want;
        logic [127:0] e;
        fr[u] = 4'(d);
        exp_q.push_back(exp);
        cmd(u, 2, lat);
        want = lg ? 2 * kk(d, u + 1) + 3 : kk(d, u + 1) + 2;
        check("fin_lat", u, 128'(lat), 128'(want));
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty u=%0d: got 0 want 1", u);
        end else begin
            e = exp_q.pop_front();
            check("digest", u, word[u], e);
            check("valid", u, 128'(vld[u]), 128'(1));
        end
    endtask

    task automatic run_vec(input int u, input vec_t v);
        int lat;
        lng[u] = v.lg;
        cmd(u, 0, lat);
        check("init_lat", u, 128'(lat), 128'(1));
        check("init_valid", u, 128'(vld[u]), 128'(0));
        cr[u] = 4'(v.c);
        for (int w = 0; w < v.nw; w++) begin
            mi[u] = (w == 0) ? v.m0 : (w == 1) ? v.m1 : v.m2;
            cmd(u, 1, lat);
            check("comp_lat", u, 128'(lat), 128'(kk(v.c, u + 1) + 2));
        end
        do_final(u, v.lg, v.d, v.exp);
    endtask

    task automatic set_vec(input int i, input logic lg, input int nw,
                           input logic [63:0] m0, input logic [63:0] m1,
                           input logic [63:0] m2, input int c,
                           input int d, input logic [127:0] exp);
        vt[i].lg  = lg;
        vt[i].nw  = nw;
        vt[i].m0  = m0;
        vt[i].m1  = m1;
        vt[i].m2  = m2;
        vt[i].c   = c;
        vt[i].d   = d;
        vt[i].exp = exp;
    endtask

    initial begin
        int lat;
        logic [127:0] r;

        key = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
        set_vec(0, 1'b0, 1, 64'h0, 64'h0, 64'h0, 2, 4,
                {64'h0, 64'h726fdb47dd0e0e31});
        set_vec(1, 1'b0, 2, 64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
                64'h0, 2, 4, {64'h0, 64'ha129ca6149be45e5});
        set_vec(2, 1'b1, 1, 64'h0, 64'h0, 64'h0, 2, 4,
                {64'h930255c71472f66d, 64'he6a825ba047f81a3});
        set_vec(3, 1'b0, 3, 64'h0123456789abcdef, 64'hfedcba9876543210,
                64'h5555aaaa3333cccc, 1, 3, '0);
        set_vec(4, 1'b1, 2, 64'hdeadbeefcafef00d, 64'h1122334455667788,
                64'h0, 3, 5, '0);
        set_vec(5, 1'b0, 1, 64'h8000000000000001, 64'h0, 64'h0, 0, 0, '0);
        for (int i = 3; i < 6; i++) begin
            ref_hash(vt[i], r);
            vt[i].exp = r;
        end

        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            ini[u] = 1'b0; cmp[u] = 1'b0; fin[u] = 1'b0; lng[u] = 1'b0;
            cr[u] = 4'd2;  fr[u] = 4'd4;  mi[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_ready", u, 128'(rdy[u]), 128'(1));
            check("rst_valid", u, 128'(vld[u]), 128'(0));
            check("rst_word", u, word[u], 128'(0));
            check("rst_err", u, 128'(err[u]), 128'(0));
        end
        reset_n = 1'b1;
        @(negedge clk);

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 6; i++)
                run_vec(u, vt[i]);

        for (int u = 0; u < 2; u++) begin
            // Command while busy is dropped and flagged for one cycle.
            lng[u] = 1'b0;
            cmd(u, 0, lat);
            mi[u] = '0;
            cr[u] = 4'd2;
            cmp[u] = 1'b1;
            @(negedge clk);
            cmp[u] = 1'b0;
            @(negedge clk);
            check("err_quiet", u, 128'(err[u]), 128'(0));
            mi[u] = 64'hffffffffffffffff;
            cmp[u] = 1'b1;
            @(negedge clk);
            cmp[u] = 1'b0;
            mi[u] = '0;
            check("err_pulse", u, 128'(err[u]), 128'(1));
            @(negedge clk);
            check("err_clear", u, 128'(err[u]), 128'(0));
            lat = 0;
            while (!rdy[u] && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            do_final(u, 1'b0, 4, vt[0].exp);

            // All three commands at once: only initialize takes effect.
            ini[u] = 1'b1; cmp[u] = 1'b1; fin[u] = 1'b1;
            @(negedge clk);
            ini[u] = 1'b0; cmp[u] = 1'b0; fin[u] = 1'b0;
            check("prio_ready", u, 128'(rdy[u]), 128'(1));
            check("prio_valid", u, 128'(vld[u]), 128'(0));
            cmd(u, 1, lat);
            check("prio_comp_lat", u, 128'(lat), 128'(kk(2, u + 1) + 2));
            do_final(u, 1'b0, 4, vt[0].exp);
        end

        // Reset in the middle of finalization discards everything.
        lng[0] = 1'b0;
        cmd(0, 0, lat);
        cr[0] = 4'd2;
        mi[0] = '0;
        cmd(0, 1, lat);
        fr[0] = 4'd4;
        fin[0] = 1'b1;
        @(negedge clk);
        fin[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 0, 128'(rdy[0]), 128'(0));
        reset_n = 1'b0;
        #2;
        check("mid_rst_ready", 0, 128'(rdy[0]), 128'(1));
        check("mid_rst_valid", 0, 128'(vld[0]), 128'(0));
        check("mid_rst_word", 0, word[0], 128'(0));
        check("mid_rst_word1", 1, word[1], 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_vec(0, vt[0]);
        run_vec(1, vt[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
